adc_resp_averager: RTL

- Sits directly downstream of the modular ADC response port, in the same clock domain as the ADC's system clock.
- Accumulates 2^LOG2_AVG consecutive samples per channel and emits one rounded 12-bit average per channel block.
- Averages leave on a valid/ready stream through a small output FIFO, because the ADC response stream has no backpressure.
- Flags channel-range and FIFO-overflow conditions for software.

---
 rtl/adc_pkg.sv | 10 +
 rtl/adc_avg_fifo.sv | 62 ++++++
 rtl/adc_resp_averager.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared widths and the result record carried through the averager output FIFO.
package adc_pkg;
  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  typedef struct packed {
    logic [ADC_CH_W-1:0]   channel;
    logic [ADC_DATA_W-1:0] data;
  } adc_result_t;
endpackage

// File: rtl/adc_avg_fifo.sv
// Show-ahead synchronous FIFO; the head output keeps the last popped word while empty.
module adc_avg_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      level_reg;
  logic [WIDTH-1:0] last_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign level   = level_reg;
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_reg : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      last_reg   <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      last_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        last_reg   <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/adc_resp_averager.sv
// Per-channel block averager for the ADC response stream, with a buffered valid/ready output.
module adc_resp_averager
  import adc_pkg::*;
#(
  parameter int NUM_CH     = 9,
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock_clk,
  input  logic                  reset_sink_reset_n,
  input  logic                  resp_valid,
  input  logic [ADC_CH_W-1:0]   resp_channel,
  input  logic [ADC_DATA_W-1:0] resp_data,
  input  logic                  resp_startofpacket,
  input  logic                  resp_endofpacket,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADC_CH_W-1:0]   out_channel,
  output logic [ADC_DATA_W-1:0] out_data,
  output logic                  overflow,
  output logic                  bad_channel,
  output logic [LVL_W-1:0]      fifo_level
);
  localparam int SUM_W = ADC_DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [SUM_W-1:0] ROUND   = (LOG2_AVG > 0) ? SUM_W'(1 << (LOG2_AVG - 1)) : '0;

  logic [NUM_CH*SUM_W-1:0] sum_flat;
  logic [NUM_CH*CNT_W-1:0] cnt_flat;
  logic [SUM_W-1:0]        sel_sum;
  logic [CNT_W-1:0]        sel_cnt;
  logic [SUM_W-1:0]        sum_next;
  logic [SUM_W-1:0]        total;
  logic                    in_range;
  logic                    accept;
  logic                    is_final;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    overflow_reg;
  logic                    bad_channel_reg;
  adc_result_t             push_result;
  adc_result_t             head_result;
  logic                    unused_sop_eop;

  assign unused_sop_eop = resp_startofpacket ^ resp_endofpacket;

  assign in_range = ({1'b0, resp_channel} < (ADC_CH_W+1)'(NUM_CH));
  assign accept   = resp_valid & in_range & ~clear;

  always_comb begin
    sel_sum = '0;
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (resp_channel == ADC_CH_W'(i)) begin
        sel_sum = sum_flat[i*SUM_W +: SUM_W];
        sel_cnt = cnt_flat[i*CNT_W +: CNT_W];
      end
    end
  end

  // With LOG2_AVG=0 there is no counter: every sample closes a block.
  assign is_final = (LOG2_AVG == 0) || (sel_cnt == CNT_MAX);
  assign sum_next = sel_sum + SUM_W'(resp_data);
  // The full-block total plus rounding always fits SUM_W bits, so no carry-out is lost.
  assign total    = sum_next + ROUND;

  assign push_result.channel = resp_channel;
  assign push_result.data    = ADC_DATA_W'(total >> LOG2_AVG);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SUM_W-1:0] sum_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             hit;

      assign hit = accept && (resp_channel == ADC_CH_W'(gi));
      assign sum_flat[gi*SUM_W +: SUM_W] = sum_reg;
      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;

      always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
          sum_reg <= '0;
          cnt_reg <= '0;
        end else if (clear) begin
          sum_reg <= '0;
          cnt_reg <= '0;
        end else if (hit) begin
          if (is_final) begin
            sum_reg <= '0;
            cnt_reg <= '0;
          end else begin
            sum_reg <= sum_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  assign push = accept & is_final;
  assign pop  = out_valid & out_ready & ~clear;

  adc_avg_fifo #(
    .WIDTH ($bits(adc_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock_clk),
    .rst_n     (reset_sink_reset_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_result),
    .pop       (pop),
    .head      (head_result),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      overflow_reg    <= 1'b0;
      bad_channel_reg <= 1'b0;
    end else if (clear) begin
      overflow_reg    <= 1'b0;
      bad_channel_reg <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
      if (resp_valid && !in_range)   bad_channel_reg <= 1'b1;
    end
  end

  assign out_valid   = ~fifo_empty;
  assign out_channel = head_result.channel;
  assign out_data    = head_result.data;
  assign overflow    = overflow_reg;
  assign bad_channel = bad_channel_reg;
endmodule
